if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 16-bit pipelined core. It is the consumer end of the decode stage's redirect interface: it owns the PC and fetches instructions over a req/ack instruction-memory port. It loads the IF/ID pipeline register that feeds the decoder with `instr` and `pcplus1`. It honours hazard-unit stalls and branch/jump redirects from decode, and carries a one-entry skid buffer so an instruction that arrives during a stall is never refetched.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 16: PC and memory address width.
- `INSTR_WIDTH`, 16: instruction width.
- `RESET_PC`, 16'h0000: PC value after reset.
- `NOP_INSTR`, 16'h0800: bubble instruction inserted on flush or empty fetch.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall_i`  in  1: hazard unit, freeze IF/ID and PC.
- `ifbranch_i`  in  1: decode, branch taken this cycle.
- `branch_addr_i`  in  ADDRESS_WIDTH: branch target.
- `isjump_i`  in  1: decode, register jump this cycle.
- `address_jr_i`  in  ADDRESS_WIDTH: jump target (register value).
- `imem_req_o`  out  1: fetch request, level, held until ack.
- `imem_addr_o`  out  ADDRESS_WIDTH: fetch address, equals PC.
- `imem_ack_i`  in  1: memory returns `imem_data_i` valid this cycle.
- `imem_data_i`  in  INSTR_WIDTH: fetched instruction.
- `instr_o`  out  INSTR_WIDTH: IF/ID instruction register.
- `pcplus1_o`  out  ADDRESS_WIDTH: IF/ID PC+1 register.
- `pc_o`  out  ADDRESS_WIDTH: current PC, for debug.

## Operation
- The stage has no delay slot. The instruction in fetch when a redirect arrives is discarded.
- Redirect: `redir = !stall_i && (isjump_i || ifbranch_i)`.
- Target: `isjump_i ? address_jr_i : branch_addr_i`. Jump wins if both are asserted.
- Stall priority: `stall_i` overrides redirect. Decode re-presents the redirect after the stall releases.
- PC+1 arithmetic is modulo 2^16; 16'hFFFF+1 = 16'h0000.
- State FETCH: `imem_req_o`=1, `imem_addr_o`=PC. Actions by priority:
  - `redir`: PC←target, `instr_o`←NOP_INSTR, any ack data is dropped, stay in FETCH. The memory must tolerate an address change while req is held.
  - ack and `stall_i`: buf←`imem_data_i`, buf_pc1←PC+1, PC←PC+1, go to HOLD. IF/ID is unchanged.
  - ack, no stall: `instr_o`←`imem_data_i`, `pcplus1_o`←PC+1, PC←PC+1.
  - no ack, `stall_i`: IF/ID and PC are unchanged.
  - no ack, no stall: `instr_o`←NOP_INSTR (bubble). `pcplus1_o` and PC are unchanged.
- State HOLD: `imem_req_o`=0. Actions by priority:
  - `stall_i`: stay in HOLD, everything unchanged.
  - `redir`: buffer discarded, PC←target, `instr_o`←NOP_INSTR, go to FETCH.
  - otherwise: `instr_o`←buf, `pcplus1_o`←buf_pc1, go to FETCH.
- `imem_req_o` = (state==FETCH) && !`rst`. It depends on state only, with no combinational path from `stall_i`, `imem_ack_i` or the redirect inputs.

## Timing
- Reset values, applied on the edge where `rst`=1:
  - PC=RESET_PC, state=FETCH.
  - `instr_o`=NOP_INSTR, `pcplus1_o`=0, buf=NOP_INSTR, buf_pc1=0.
  - `imem_req_o`=0 while `rst` is high.
- First request is issued in the first cycle with `rst` low, at address RESET_PC.
- Latency: with single-cycle ack, an instruction at address A appears on `instr_o` the cycle after its request. Throughput is one instruction per cycle.
- A redirect seen at edge N makes `imem_addr_o`=target in cycle N+1, and `instr_o`=NOP_INSTR after edge N.
- Reset asserted mid-operation (FETCH waiting, or HOLD) abandons the request and buffer with no residue. A late ack after reset is ignored because req was low.
- Stall and redirect in the same cycle: stall wins; the redirect has no effect.
- Stall and ack in the same cycle: the data is buffered, not lost, and not refetched.

## Test plan
- Reset then free-run, with memory returning mem[A]=A^16'hA5A5 and ack every cycle. `imem_addr_o` runs 0,1,2… `instr_o`/`pcplus1_o` = (A^16'hA5A5, A+1) one cycle later.
- Memory ack delayed 3 cycles on addr 5: `instr_o`=16'h0800 for those 3 cycles, PC stays 5, then the addr-5 instruction arrives with `pcplus1_o`=6.
- `stall_i` high for 4 cycles coincident with an ack at addr 9: HOLD is entered and `imem_req_o`=0. IF/ID holds the addr-8 values. On release, `instr_o`=mem[9] and `pcplus1_o`=10 with no re-request of 9, and the next request is addr 10.
- `ifbranch_i`=1, `branch_addr_i`=16'h0040 while fetching addr 3: `instr_o`=16'h0800 next cycle, then the next request is 16'h0040. With `isjump_i`=1 and `address_jr_i`=16'h1234 asserted together with the branch, the target is 16'h1234.
- Redirect with `stall_i`=1: no PC change. Redirect in HOLD with stall released: buffer dropped, `instr_o`=NOP, fetch at the target.
- PC at 16'hFFFF with ack: `pcplus1_o`=16'h0000 and the next `imem_addr_o`=16'h0000. Reset pulsed during HOLD: PC=0, `instr_o`=16'h0800, FETCH on the next cycle.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 16-bit pipelined core.
// Owns the PC, issues level req/ack fetches to instruction memory, loads the
// IF/ID register (instr_o / pcplus1_o), honours hazard stalls and decode
// redirects, and keeps a one-entry skid buffer so that an instruction that
// arrives during a stall is parked instead of being refetched.
module if_stage #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       INSTR_WIDTH   = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR     = 16'h0800
) (
  input  logic                     clk,
  input  logic                     rst,
  // hazard unit
  input  logic                     stall_i,
  // decode redirect interface
  input  logic                     ifbranch_i,
  input  logic [ADDRESS_WIDTH-1:0] branch_addr_i,
  input  logic                     isjump_i,
  input  logic [ADDRESS_WIDTH-1:0] address_jr_i,
  // instruction memory port
  output logic                     imem_req_o,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic                     imem_ack_i,
  input  logic [INSTR_WIDTH-1:0]   imem_data_i,
  // IF/ID pipeline register
  output logic [INSTR_WIDTH-1:0]   instr_o,
  output logic [ADDRESS_WIDTH-1:0] pcplus1_o,
  // debug
  output logic [ADDRESS_WIDTH-1:0] pc_o
);

  // FETCH: request outstanding at PC. HOLD: a fetched instruction is parked
  // in the skid buffer while the pipeline is stalled; no request is issued.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_next;

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_next;
  logic [ADDRESS_WIDTH-1:0] pc_inc;

  logic [INSTR_WIDTH-1:0]   instr;
  logic [INSTR_WIDTH-1:0]   instr_next;
  logic [ADDRESS_WIDTH-1:0] pcplus1;
  logic [ADDRESS_WIDTH-1:0] pcplus1_next;

  logic [INSTR_WIDTH-1:0]   skid_instr;
  logic [INSTR_WIDTH-1:0]   skid_instr_next;
  logic [ADDRESS_WIDTH-1:0] skid_pc1;
  logic [ADDRESS_WIDTH-1:0] skid_pc1_next;

  logic                     redir;
  logic [ADDRESS_WIDTH-1:0] target;

  // Redirect decode: a stall suppresses the redirect entirely, decode will
  // present it again once the stall releases. Jump wins over branch.
  assign redir  = !stall_i && (isjump_i || ifbranch_i);
  assign target = isjump_i ? address_jr_i : branch_addr_i;

  // PC increment wraps naturally at 2^ADDRESS_WIDTH.
  assign pc_inc = pc + ADDRESS_WIDTH'(1);

  // Memory port: request depends on state only, never on same-cycle inputs.
  assign imem_req_o  = (state == FETCH) && !rst;
  assign imem_addr_o = pc;

  assign instr_o   = instr;
  assign pcplus1_o = pcplus1;
  assign pc_o      = pc;

  // State register, PC, IF/ID register and skid buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      instr      <= NOP_INSTR;
      pcplus1    <= '0;
      // NOTE: the skid buffer is always written before HOLD reads it, but it
      // is reset anyway so a reset mid-stall leaves no stale instruction.
      skid_instr <= NOP_INSTR;
      skid_pc1   <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      instr      <= instr_next;
      pcplus1    <= pcplus1_next;
      skid_instr <= skid_instr_next;
      skid_pc1   <= skid_pc1_next;
    end
  end

  // Next-state and datapath selection for both states, by priority.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no branch below
    // can leave one unassigned and infer a latch.
    state_next      = state;
    pc_next         = pc;
    instr_next      = instr;
    pcplus1_next    = pcplus1;
    skid_instr_next = skid_instr;
    skid_pc1_next   = skid_pc1;

    unique case (state)
      FETCH: begin
        if (redir) begin
          // No delay slot: whatever is in flight (even if acked) is dropped.
          pc_next    = target;
          instr_next = NOP_INSTR;
        end else if (imem_ack_i && stall_i) begin
          // Data arrived while IF/ID is frozen: park it, do not refetch.
          skid_instr_next = imem_data_i;
          skid_pc1_next   = pc_inc;
          pc_next         = pc_inc;
          state_next      = HOLD;
        end else if (imem_ack_i) begin
          instr_next   = imem_data_i;
          pcplus1_next = pc_inc;
          pc_next      = pc_inc;
        end else if (!stall_i) begin
          // Memory still busy: feed a bubble to decode, keep requesting.
          instr_next = NOP_INSTR;
        end
      end

      HOLD: begin
        if (stall_i) begin
          state_next = HOLD;
        end else if (redir) begin
          // The parked instruction is on the wrong path: discard it.
          pc_next    = target;
          instr_next = NOP_INSTR;
          state_next = FETCH;
        end else begin
          instr_next   = skid_instr;
          pcplus1_next = skid_pc1;
          state_next   = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a table of per-cycle vectors (inputs plus
// expected pre-edge memory-port outputs and post-edge IF/ID contents), then
// hand-written sequences for reset behaviour.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        ifbranch_i;
  logic [15:0] branch_addr_i;
  logic        isjump_i;
  logic [15:0] address_jr_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_data_i;
  logic [15:0] instr_o;
  logic [15:0] pcplus1_o;
  logic [15:0] pc_o;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] NOP = 16'h0800;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .ifbranch_i    (ifbranch_i),
    .branch_addr_i (branch_addr_i),
    .isjump_i      (isjump_i),
    .address_jr_i  (address_jr_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_o       (instr_o),
    .pcplus1_o     (pcplus1_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus and the values expected for it.
  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] baddr;
    logic        jmp;
    logic [15:0] jaddr;
    logic        ack;
    logic        req;    // expected before the edge
    logic [15:0] addr;   // expected before the edge (also pc_o)
    logic [15:0] instr;  // expected after the edge
    logic [15:0] pc1;    // expected after the edge
  } vec_t;

  vec_t vecs[$];

  // Memory contents model.
  function automatic logic [15:0] mem(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic b,
                              input logic [15:0] ba, input logic j,
                              input logic [15:0] ja, input logic a,
                              input logic rq, input logic [15:0] ad,
                              input logic [15:0] ins, input logic [15:0] p1);
    vec_t v;
    v.rst = r;  v.stall = s; v.br = b; v.baddr = ba; v.jmp = j; v.jaddr = ja;
    v.ack = a;  v.req = rq;  v.addr = ad; v.instr = ins; v.pc1 = p1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drive one vector mid-cycle, check the memory port before the edge and
  // the IF/ID register after it.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst           = v.rst;
    stall_i       = v.stall;
    ifbranch_i    = v.br;
    branch_addr_i = v.baddr;
    isjump_i      = v.jmp;
    address_jr_i  = v.jaddr;
    imem_ack_i    = v.ack;
    imem_data_i   = v.ack ? mem(v.addr) : 16'hDEAD;
    #1;
    check({tag, ".req"},  {31'd0, imem_req_o}, {31'd0, v.req});
    check({tag, ".addr"}, {16'd0, imem_addr_o}, {16'd0, v.addr});
    check({tag, ".pc"},   {16'd0, pc_o},        {16'd0, v.addr});
    @(posedge clk);
    #1;
    check({tag, ".instr"}, {16'd0, instr_o},   {16'd0, v.instr});
    check({tag, ".pc1"},   {16'd0, pcplus1_o}, {16'd0, v.pc1});
  endtask

  initial begin
    //           rst stall br baddr    jmp jaddr    ack req addr      instr          pc1
    // free run, single-cycle ack
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 16'hA5A5, 16'h0001));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0001, 16'hA5A4, 16'h0002));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0002, 16'hA5A7, 16'h0003));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0003, 16'hA5A6, 16'h0004));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0004, 16'hA5A1, 16'h0005));
    // ack delayed 3 cycles on addr 5: bubbles, PC holds
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0005, NOP,       16'h0005));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0005, NOP,       16'h0005));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0005, NOP,       16'h0005));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0005, 16'hA5A0, 16'h0006));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0006, 16'hA5A3, 16'h0007));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0007, 16'hA5A2, 16'h0008));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0008, 16'hA5AD, 16'h0009));
    // 4-cycle stall starting with an ack at addr 9: HOLD, IF/ID keeps addr 8
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0009, 16'hA5AD, 16'h0009));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h000A, 16'hA5AD, 16'h0009));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h000A, 16'hA5AD, 16'h0009));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h000A, 16'hA5AD, 16'h0009));
    // release: buffered addr-9 instruction delivered, no re-request of 9
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h000A, 16'hA5AC, 16'h000A));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h000A, 16'hA5AF, 16'h000B));
    // jump to 3 with ack: data dropped, bubble
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0003, 1, 1, 16'h000B, NOP,       16'h000B));
    // branch to 0x40 while fetching addr 3
    vecs.push_back(mk(0, 0, 1, 16'h0040, 0, 16'h0000, 1, 1, 16'h0003, NOP,       16'h000B));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0040, 16'hA5E5, 16'h0041));
    // branch and jump together: jump target wins
    vecs.push_back(mk(0, 0, 1, 16'h0040, 1, 16'h1234, 1, 1, 16'h0041, NOP,       16'h0041));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1234, 16'hB791, 16'h1235));
    // redirect under stall: ignored, PC unchanged
    vecs.push_back(mk(0, 1, 1, 16'h0077, 0, 16'h0000, 0, 1, 16'h1235, 16'hB791, 16'h1235));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1235, 16'hB790, 16'h1236));
    // enter HOLD, then redirect in HOLD once stall releases: buffer dropped
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1236, 16'hB790, 16'h1236));
    vecs.push_back(mk(0, 1, 1, 16'h0100, 0, 16'h0000, 0, 0, 16'h1237, 16'hB790, 16'h1236));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 0, 16'h0000, 0, 0, 16'h1237, NOP,       16'h1236));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0100, 16'hA4A5, 16'h0101));
    // PC wrap at 0xFFFF
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 1, 16'h0101, NOP,       16'h0101));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'hFFFF, 16'h5A5A, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 16'hA5A5, 16'h0001));

    // Reset and check reset state while rst is still high.
    rst = 1'b1; stall_i = 1'b0; ifbranch_i = 1'b0; branch_addr_i = '0;
    isjump_i = 1'b0; address_jr_i = '0; imem_ack_i = 1'b0; imem_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.req",   {31'd0, imem_req_o}, 32'd0);
    check("reset.addr",  {16'd0, imem_addr_o}, 32'h0000);
    check("reset.instr", {16'd0, instr_o},     {16'd0, NOP});
    check("reset.pc1",   {16'd0, pcplus1_o},   32'h0000);

    // Table-driven main run.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Reset pulsed while in HOLD (with a late ack present): no residue.
    apply(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0001, 16'hA5A5, 16'h0001), "hold_in");
    apply(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0002, NOP,       16'h0000), "hold_rst");
    apply(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, NOP,       16'h0000), "post_rst");
    apply(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 16'hA5A5, 16'h0001), "post_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
